// File: rtl/data_mem_responder.sv
// Memory side of the CPU load/store port: one request at a time, RISC-V width/sign
// decode, access performed after LATENCY cycles, response held until accepted.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [2:0]       acc_f3;
  logic [31:0]      acc_wdata;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word;
  logic             mis, oor, ill, acc_err;
  logic [3:0]       lane_en;
  logic [31:0]      wlanes;
  logic [31:0]      store_word;
  logic [31:0]      shifted;
  logic [31:0]      load_val;
  logic [31:0]      acc_rdata;
  logic             do_access;

  // With LATENCY==1 the access happens on the accept edge, straight from the request bus.
  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_f3    = (state_q == IDLE) ? req_f3    : f3_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  assign off  = acc_addr[1:0];
  assign idx  = acc_addr[IDX_W+1:2];
  assign word = mem[idx];

  assign mis     = ((acc_f3[1:0] == 2'b01) && off[0]) || ((acc_f3[1:0] == 2'b10) && (off != 2'b00));
  assign oor     = acc_addr[31:2] >= 30'(DEPTH_WORDS);
  assign ill     = (acc_f3[1:0] == 2'b11) || (acc_f3[2] && (acc_we || acc_f3[1]));
  assign acc_err = mis || oor || ill;

  always_comb begin
    lane_en = 4'b1111;
    wlanes  = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        lane_en = 4'b0001 << off;
        wlanes  = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        lane_en = off[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_word[8*gi +: 8] = lane_en[gi] ? wlanes[8*gi +: 8] : word[8*gi +: 8];
  end

  assign shifted = word >> {off, 3'b000};

  always_comb begin
    load_val = word;
    case (acc_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: ;
    endcase
  end

  assign acc_rdata = (acc_err || acc_we) ? 32'b0 : load_val;
  assign do_access = !rst && (((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                              ((state_q == BUSY) && (cnt_q == 4'd1)));

  // Storage is deliberately not reset; a store still in BUSY at reset never commits.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      mem[idx] <= store_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      f3_q    <= 3'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            f3_q    <= req_f3;
            wdata_q <= req_wdata;
            cnt_q   <= CNT_INIT;
            if (LATENCY == 1) begin
              rdata_q <= acc_rdata;
              err_q   <= acc_err;
              state_q <= RESP;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            rdata_q <= acc_rdata;
            err_q   <= acc_err;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(resp_valid && req_ready));
  a_resp_stable: assert property (@(posedge clk) disable iff (rst)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata) && $stable(resp_err)));
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded random + directed bench for data_mem_responder at LATENCY 1, 2 and 4,
// checked against a byte-addressed reference memory.
module tb_data_mem_responder;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [2:0]        req_f3;
  logic [31:0]       req_wdata;
  logic [2:0]        resp_valid;
  logic [2:0]        resp_ready;
  logic [2:0][31:0]  resp_rdata;
  logic [2:0]        resp_err;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (gi == 0 ? 1 : (gi == 1 ? 2 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[gi]),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready[gi]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_f3    (req_f3),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid[gi]),
      .resp_ready(resp_ready[gi]),
      .resp_rdata(resp_rdata[gi]),
      .resp_err  (resp_err[gi])
    );
  end

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    longint      acc;
  } exp_t;

  exp_t   sb[$];
  exp_t   cur[3];
  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;
  bit     rand_ready = 1'b0;
  logic [7:0] mb [3][DEPTH*4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic void chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, req);
    end
  endfunction

  // Reference: byte-addressed memory, access size 1/2/4 bytes from funct3.
  function automatic void model(input int k, input bit we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    rd = 32'b0;
    e = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (we && f3 >= 3'b100)
        || ((addr & 32'(size - 1)) != 0) || (addr / 4 >= 32'(DEPTH));
    if (!e) begin
      if (we) begin
        for (int i = 0; i < size; i++) mb[k][int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'b0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mb[k][int'(addr) + i];
        if (f3[2] == 1'b0 && size < 4 && v[8*size-1]) begin
          for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        rd = v;
      end
    end
  endfunction

  task automatic issue(input int k, input bit we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input int stall);
    exp_t e;
    int   t;
    bit   rr;
    model(k, we, addr, f3, wd, e.rdata, e.err);
    e.k = k;
    req_we = we; req_addr = addr; req_f3 = f3; req_wdata = wd;
    req_valid[k] = 1'b1;
    t = 0;
    while (!req_ready[k] && t < 100) begin @(negedge clk); t++; end
    if (!req_ready[k]) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout dut%0d: req_ready=0 after %0d cycles, expected 1", k, t);
      req_valid[k] = 1'b0;
      return;
    end
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_we = 1'($urandom_range(0, 1)); req_addr = $urandom; req_f3 = 3'($urandom_range(0, 7)); req_wdata = $urandom;
    t = 0;
    while (!resp_valid[k] && t < 100) begin @(negedge clk); t++; end
    if (!resp_valid[k]) begin
      n_chk++; n_fail++;
      $display("FAIL resp_timeout dut%0d: resp_valid=0 after %0d cycles, expected 1", k, t);
      return;
    end
    if (stall > 0) begin
      resp_ready[k] = 1'b0;
      req_valid[k] = 1'b1;
      repeat (stall) begin
        chk("busy_no_accept", k, 32'(req_ready[k]), 32'd0);
        @(negedge clk);
      end
      req_valid[k] = 1'b0;
    end
    t = 0;
    forever begin
      rr = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (t > 50) rr = 1'b1;
      resp_ready[k] = rr;
      @(negedge clk);
      t++;
      if (rr) break;
    end
    resp_ready[k] = 1'b0;
    chk("post_hs_req_ready", k, 32'(req_ready[k]), 32'd1);
    chk("post_hs_resp_valid", k, 32'(resp_valid[k]), 32'd0);
  endtask

  task automatic rand_txn(input int k);
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          r;
    int          size;
    case ($urandom_range(0, 5))
      0: f3 = 3'b000;
      1: f3 = 3'b001;
      2: f3 = 3'b010;
      3: f3 = 3'b100;
      4: f3 = 3'b101;
      default: f3 = 3'($urandom_range(0, 7));
    endcase
    we = 1'($urandom_range(0, 1));
    if (we && f3[2] && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
    r = int'($urandom_range(0, 19));
    if (r == 0) addr = $urandom;
    else if (r < 3) addr = 32'(4 * DEPTH - 8) + $urandom_range(0, 15);
    else addr = $urandom_range(0, 4 * DEPTH - 1);
    size = 1 << f3[1:0];
    if ($urandom_range(0, 4) != 0 && size <= 4) addr = addr & ~32'(size - 1);
    issue(k, we, addr, f3, $urandom, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0);
  endtask

  // Monitor: samples 2 time units after the falling edge, once the driver has settled.
  initial begin
    bit pv[3];
    bit pr[3];
    exp_t e;
    for (int k = 0; k < 3; k++) begin pv[k] = 1'b0; pr[k] = 1'b0; end
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        if (!rst[k]) begin
          n_chk++;
          if (resp_valid[k] && req_ready[k]) begin
            n_fail++;
            $display("FAIL proto_overlap dut%0d: resp_valid=1 req_ready=1, expected not both", k);
          end
          if (resp_valid[k] && !pv[k]) begin
            if (sb.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL unexpected_resp dut%0d: response with 0 outstanding, expected none", k);
            end else begin
              e = sb.pop_front();
              cur[k] = e;
              chk("resp_dut", k, 32'(k), 32'(e.k));
              chk("resp_latency", k, 32'(cyc - e.acc), 32'(lat_of(k)));
              chk("resp_rdata", k, resp_rdata[k], e.rdata);
              chk("resp_err", k, 32'(resp_err[k]), 32'(e.err));
            end
          end else if (resp_valid[k] && pv[k] && !pr[k]) begin
            chk("hold_rdata", k, resp_rdata[k], cur[k].rdata);
            chk("hold_err", k, 32'(resp_err[k]), 32'(cur[k].err));
          end
        end
        pv[k] = resp_valid[k] && !rst[k];
        pr[k] = resp_ready[k];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 3'b111; req_valid = 3'b000; resp_ready = 3'b000;
    req_we = 1'b0; req_addr = 32'b0; req_f3 = 3'b0; req_wdata = 32'b0;
    repeat (3) @(negedge clk);
    rst = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_req_ready", k, 32'(req_ready[k]), 32'd1);
      chk("reset_resp_valid", k, 32'(resp_valid[k]), 32'd0);
      chk("reset_resp_rdata", k, resp_rdata[k], 32'd0);
      chk("reset_resp_err", k, 32'(resp_err[k]), 32'd0);
    end

    for (int k = 0; k < 3; k++)
      for (int w = 0; w < DEPTH; w++) issue(k, 1'b1, 32'(4 * w), 3'b010, $urandom, 0);

    issue(1, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0);
    issue(1, 1'b0, 32'h10, 3'b010, 32'h0, 0);
    issue(1, 1'b1, 32'h12, 3'b000, 32'h0000007F, 0);
    issue(1, 1'b0, 32'h12, 3'b000, 32'h0, 0);
    issue(1, 1'b0, 32'h13, 3'b100, 32'h0, 0);
    issue(1, 1'b0, 32'h10, 3'b001, 32'h0, 0);
    issue(1, 1'b0, 32'h11, 3'b001, 32'h0, 0);
    issue(1, 1'b1, 32'h16, 3'b010, 32'hAAAAAAAA, 0);
    issue(1, 1'b0, 32'h14, 3'b011, 32'h0, 0);
    issue(1, 1'b1, 32'h14, 3'b100, 32'h55555555, 0);
    issue(1, 1'b0, 32'h14, 3'b010, 32'h0, 0);
    issue(1, 1'b0, 32'(4 * DEPTH), 3'b010, 32'h0, 0);
    issue(1, 1'b1, 32'(4 * (DEPTH - 1)), 3'b010, 32'h12345678, 0);
    issue(1, 1'b0, 32'(4 * (DEPTH - 1)), 3'b010, 32'h0, 0);
    issue(1, 1'b0, 32'h10, 3'b010, 32'h0, 5);
    issue(1, 1'b0, 32'h14, 3'b101, 32'h0, 0);
    issue(0, 1'b1, 32'h20, 3'b001, 32'h0000C0DE, 0);
    issue(0, 1'b0, 32'h20, 3'b001, 32'h0, 0);

    rand_ready = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 150; n++) rand_txn(k);
    rand_ready = 1'b0;

    // Reset two cycles into a LATENCY=4 store: the store must not commit.
    issue(2, 1'b1, 32'h30, 3'b010, 32'h11111111, 0);
    req_we = 1'b1; req_addr = 32'h30; req_f3 = 3'b010; req_wdata = 32'hCAFEF00D;
    req_valid[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    chk("rst_resp_valid", 2, 32'(resp_valid[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_after_req_ready", 2, 32'(req_ready[2]), 32'd1);
    chk("rst_after_resp_valid", 2, 32'(resp_valid[2]), 32'd0);
    issue(2, 1'b0, 32'h30, 3'b010, 32'h0, 0);

    repeat (10) @(negedge clk);
    chk("sb_drain", 0, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
